// File: rtl/io_bus_controller.sv
// CPU-to-external-bus handshake controller: IDLE -> REQ -> RELEASE per transaction.
// Optional bus timeout abort enabled by defining IO_TIMEOUT_EN.
module io_bus_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cpu_store,
    input  logic       cpu_load,
    input  logic [2:0] data_type,
    input  logic [1:0] data_offset,
    input  logic       bus_ack,
    output logic       cpu_busy,
    output logic       cpu_error,
    output logic       io_store,
    output logic       io_load,
    output logic       bus_req,
    output logic       bus_write,
    output logic [3:0] bus_byte_en
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRelease
    } state_e;

    localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

    state_e     state_q, state_d;
    logic       write_q, write_d;
    logic [3:0] be_q, be_d;
    logic       pend_q, pend_d;
    logic [3:0] be_new;
    logic       timeout;

    // data_type[2] does not affect lane selection
    logic unused_type;
    assign unused_type = data_type[2];

    always_comb begin
        be_new = 4'b1111;
        unique case (data_type[1:0])
            2'b00:   be_new = 4'b0001 << data_offset;
            2'b01:   be_new = 4'b0011 << data_offset;
            default: be_new = 4'b1111;
        endcase
    end

`ifdef IO_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counter holds the number of ack-less REQ cycles; it is zero on every REQ entry.
    always_comb begin
        cnt_d   = '0;
        timeout = 1'b0;
        if (state_q == StReq && !bus_ack) begin
            cnt_d   = cnt_q + 16'd1;
            timeout = (cnt_d == TimeoutLimit);
        end else if (state_q == StReq) begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = ^TimeoutLimit;
    assign timeout      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        be_d        = be_q;
        pend_d      = pend_q;
        cpu_error   = 1'b0;
        io_store    = 1'b0;
        io_load     = 1'b0;
        bus_req     = 1'b0;
        bus_write   = 1'b0;
        bus_byte_en = 4'b0000;
        unique case (state_q)
            StIdle: begin
                // A load deferred behind a simultaneous store wins over new requests.
                if (pend_q) begin
                    write_d = 1'b0;
                    pend_d  = 1'b0;
                    state_d = StReq;
                end else if (cpu_store) begin
                    io_store = reset_n;
                    write_d  = 1'b1;
                    be_d     = be_new;
                    pend_d   = cpu_load;
                    state_d  = StReq;
                end else if (cpu_load) begin
                    write_d = 1'b0;
                    be_d    = be_new;
                    state_d = StReq;
                end
            end
            StReq: begin
                bus_req     = 1'b1;
                bus_write   = write_q;
                bus_byte_en = be_q;
                if (bus_ack) begin
                    io_load = !write_q;
                    state_d = StRelease;
                end else if (timeout) begin
                    cpu_error = 1'b1;
                    state_d   = StRelease;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign cpu_busy = (state_q != StIdle);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            be_q    <= 4'b0000;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            be_q    <= be_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_io_bus_controller.sv
// Directed scoreboard bench for io_bus_controller; expected output vectors are queued
// with each stimulus cycle and compared mid-cycle.
module tb_io_bus_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cpu_store, cpu_load, bus_ack;
    logic [2:0] data_type;
    logic [1:0] data_offset;
    logic       cpu_busy, cpu_error, io_store, io_load, bus_req, bus_write;
    logic [3:0] bus_byte_en;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    io_bus_controller #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_store  (cpu_store),
        .cpu_load   (cpu_load),
        .data_type  (data_type),
        .data_offset(data_offset),
        .bus_ack    (bus_ack),
        .cpu_busy   (cpu_busy),
        .cpu_error  (cpu_error),
        .io_store   (io_store),
        .io_load    (io_load),
        .bus_req    (bus_req),
        .bus_write  (bus_write),
        .bus_byte_en(bus_byte_en)
    );

    wire [9:0] outs = {cpu_busy, cpu_error, io_store, io_load, bus_req, bus_write, bus_byte_en};

    // {busy, error, io_store, io_load, bus_req, bus_write, byte_en}
    function automatic logic [9:0] ev(input logic busy, input logic err, input logic ios,
                                      input logic iol, input logic req, input logic wr,
                                      input logic [3:0] be);
        return {busy, err, ios, iol, req, wr, be};
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; drives one cycle, queues its expectation, checks at negedge.
    task automatic cyc(input logic st, input logic ld, input logic [2:0] dt,
                       input logic [1:0] off, input logic ack, input logic [9:0] exp,
                       input string tag);
        exp_t e;
        cpu_store   = st;
        cpu_load    = ld;
        data_type   = dt;
        data_offset = off;
        bus_ack     = ack;
        sb.push_back('{tag, exp});
        @(negedge clock);
        e = sb.pop_front();
        chk(e.tag, outs, e.v);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        cpu_store   = 1'b1;
        cpu_load    = 1'b1;
        data_type   = 3'b000;
        data_offset = 2'd0;
        bus_ack     = 1'b1;
        #2;
        chk("reset_outputs", outs, 10'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Byte store, offset 2, ack in third REQ cycle; load during REQ ignored
        cyc(1, 0, 3'b000, 2'd2, 0, ev(0, 0, 1, 0, 0, 0, 4'b0000), "bst_req");
        cyc(0, 1, 3'b000, 2'd2, 0, ev(1, 0, 0, 0, 1, 1, 4'b0100), "bst_r1");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 1, 1, 4'b0100), "bst_r2");
        cyc(0, 0, 3'b000, 2'd0, 1, ev(1, 0, 0, 0, 1, 1, 4'b0100), "bst_r3_ack");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 0, 0, 4'b0000), "bst_release");
        cyc(0, 0, 3'b000, 2'd0, 1, ev(0, 0, 0, 0, 0, 0, 4'b0000), "bst_idle_ack");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(0, 0, 0, 0, 0, 0, 4'b0000), "bst_idle2");

        // Half load, offset 3, immediate ack; ack in RELEASE ignored
        cyc(0, 1, 3'b001, 2'd3, 0, ev(0, 0, 0, 0, 0, 0, 4'b0000), "hld_req");
        cyc(0, 0, 3'b000, 2'd0, 1, ev(1, 0, 0, 1, 1, 0, 4'b1000), "hld_ack");
        cyc(0, 0, 3'b000, 2'd0, 1, ev(1, 0, 0, 0, 0, 0, 4'b0000), "hld_release");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(0, 0, 0, 0, 0, 0, 4'b0000), "hld_idle");

        // Half store, offset 2
        cyc(1, 0, 3'b001, 2'd2, 0, ev(0, 0, 1, 0, 0, 0, 4'b0000), "hst_req");
        cyc(0, 0, 3'b000, 2'd0, 1, ev(1, 0, 0, 0, 1, 1, 4'b1100), "hst_ack");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 0, 0, 4'b0000), "hst_release");

        // Word load with data_type 111 and nonzero offset
        cyc(0, 1, 3'b111, 2'd3, 0, ev(0, 0, 0, 0, 0, 0, 4'b0000), "wld_req");
        cyc(0, 0, 3'b000, 2'd0, 1, ev(1, 0, 0, 1, 1, 0, 4'b1111), "wld_ack");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 0, 0, 4'b0000), "wld_release");

        // Simultaneous store and load, word
        cyc(1, 1, 3'b010, 2'd1, 0, ev(0, 0, 1, 0, 0, 0, 4'b0000), "both_req");
        cyc(0, 0, 3'b000, 2'd0, 1, ev(1, 0, 0, 0, 1, 1, 4'b1111), "both_st_ack");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 0, 0, 4'b0000), "both_st_rel");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(0, 0, 0, 0, 0, 0, 4'b0000), "both_pend_idle");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 1, 0, 4'b1111), "both_ld_r1");
        cyc(0, 0, 3'b000, 2'd0, 1, ev(1, 0, 0, 1, 1, 0, 4'b1111), "both_ld_ack");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 0, 0, 4'b0000), "both_ld_rel");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(0, 0, 0, 0, 0, 0, 4'b0000), "both_idle");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(0, 0, 0, 0, 0, 0, 4'b0000), "both_no_extra");

`ifdef IO_TIMEOUT_EN
        // Store times out on the fourth ack-less REQ cycle; pending load still runs
        cyc(1, 1, 3'b000, 2'd1, 0, ev(0, 0, 1, 0, 0, 0, 4'b0000), "to_req");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 1, 1, 4'b0010), "to_wait");
        end
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 1, 0, 0, 1, 1, 4'b0010), "to_error");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 0, 0, 4'b0000), "to_release");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(0, 0, 0, 0, 0, 0, 4'b0000), "to_idle");
        cyc(0, 0, 3'b000, 2'd0, 1, ev(1, 0, 0, 1, 1, 0, 4'b0010), "to_pend_ack");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 0, 0, 4'b0000), "to_pend_rel");
`else
        // Without timeout support REQ waits indefinitely with cpu_error low
        cyc(1, 0, 3'b000, 2'd1, 0, ev(0, 0, 1, 0, 0, 0, 4'b0000), "nto_req");
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 1, 1, 4'b0010), "nto_wait");
        end
        cyc(0, 0, 3'b000, 2'd0, 1, ev(1, 0, 0, 0, 1, 1, 4'b0010), "nto_ack");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 0, 0, 4'b0000), "nto_release");
`endif
        cyc(0, 0, 3'b000, 2'd0, 0, ev(0, 0, 0, 0, 0, 0, 4'b0000), "pre_rst_idle");

        // Reset asserted while in REQ abandons the load
        cyc(0, 1, 3'b000, 2'd0, 0, ev(0, 0, 0, 0, 0, 0, 4'b0000), "rst_ld_req");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 1, 0, 4'b0001), "rst_ld_r1");
        bus_ack = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_immediate", outs, 10'b0);
        @(negedge clock);
        chk("rst_mid_held", outs, 10'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc(0, 0, 3'b000, 2'd0, 1, ev(0, 0, 0, 0, 0, 0, 4'b0000), "rst_after_idle");
        cyc(0, 1, 3'b001, 2'd1, 0, ev(0, 0, 0, 0, 0, 0, 4'b0000), "rst_next_req");
        cyc(0, 0, 3'b000, 2'd0, 1, ev(1, 0, 0, 1, 1, 0, 4'b0110), "rst_next_ack");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(1, 0, 0, 0, 0, 0, 4'b0000), "rst_next_rel");
        cyc(0, 0, 3'b000, 2'd0, 0, ev(0, 0, 0, 0, 0, 0, 4'b0000), "rst_next_idle");

        checks++;
        assert (sb.size() == 0)
        else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
